// File: rtl/key_command_encoder.sv
// Debounced pushbutton front end: turns clean presses of three active-low
// keys into single-cycle command codes on w, with optional auto-repeat.
`timescale 1ns/1ps

module key_command_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] key,
    output logic [1:0] w,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        FIRE     = 3'd2,
        HELD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               REP_ON   = (REPEAT_CYCLES != 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       code;
    logic [2:0]       sync1;
    logic [2:0]       ks;
    logic [1:0]       pcode;
    logic             all_up;

    assign state_dbg = state;
    assign all_up    = (ks == 3'b111);

    // Priority encode of currently pressed (low) synchronised keys; sub1 wins.
    always_comb begin
        pcode = 2'd0;
        if (!ks[2]) begin
            pcode = 2'd3;
        end else if (!ks[1]) begin
            pcode = 2'd2;
        end else if (!ks[0]) begin
            pcode = 2'd1;
        end
    end

    // Two-flop synchroniser for the raw asynchronous keys.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 3'b111;
            ks    <= 3'b111;
        end else begin
            sync1 <= key;
            ks    <= sync1;
        end
    end

    // Press/hold/release FSM; w is registered and set only on entry to FIRE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= 2'd0;
            w     <= 2'd0;
        end else begin
            w <= 2'd0;
            case (state)
                IDLE: begin
                    if (pcode != 2'd0) begin
                        code  <= pcode;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (pcode != code) begin
                        // Release, bounce or a higher-priority key restarts the press.
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        w     <= code;
                        state <= FIRE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIRE: begin
                    cnt   <= '0;
                    state <= HELD;
                end
                HELD: begin
                    if (all_up) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else if (REP_ON && (cnt == REP_LAST)) begin
                        w     <= code;
                        state <= FIRE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!all_up) begin
                        // Release bounce restarts the quiet-period count; never re-fires.
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_command_encoder.sv
// Directed bench for key_command_encoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Edge numbering: edge 1 is the first rising edge that samples the new key value.
`timescale 1ns/1ps

module tb_key_command_encoder;

    logic       clock;
    logic       reset;
    logic [2:0] key;
    logic [1:0] w;
    logic [2:0] state_dbg;

    int checks;
    int errors;

    key_command_encoder #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (8),
        .CNT_W          (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key      (key),
        .w        (w),
        .state_dbg(state_dbg)
    );

    // 40 ns clock
    initial clock = 1'b0;
    always #20 clock = ~clock;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key   = 3'b111;
        for (int e = 1; e <= 2; e++) begin
            step();
            checks++;
            if (w !== 2'd0) begin
                errors++;
                $display("FAIL reset_w edge %0d got %0d want 0", e, w);
            end
            checks++;
            if (state_dbg !== 3'd0) begin
                errors++;
                $display("FAIL reset_state edge %0d got %0d want 0", e, state_dbg);
            end
        end
        reset = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (w !== 2'd0 || state_dbg !== 3'd0) begin
                errors++;
                $display("FAIL idle_quiet edge %0d got w=%0d st=%0d want w=0 st=0", e, w, state_dbg);
            end
        end
    endtask

    task automatic test_single_press();
        logic [1:0] exp_w;
        logic [2:0] exp_st;
        for (int e = 1; e <= 22; e++) begin
            key = (e <= 12) ? 3'b110 : 3'b111;
            step();
            exp_w = (e == 7) ? 2'd1 : 2'd0;
            if (e < 3)       exp_st = 3'd0;
            else if (e < 7)  exp_st = 3'd1;
            else if (e == 7) exp_st = 3'd2;
            else if (e < 15) exp_st = 3'd3;
            else if (e < 19) exp_st = 3'd4;
            else             exp_st = 3'd0;
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL single_w edge %0d got %0d want %0d", e, w, exp_w);
            end
            checks++;
            if (state_dbg !== exp_st) begin
                errors++;
                $display("FAIL single_state edge %0d got %0d want %0d", e, state_dbg, exp_st);
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp_w;
        for (int e = 1; e <= 22; e++) begin
            if (e == 3 || e > 12) key = 3'b111;
            else                  key = 3'b101;
            step();
            exp_w = (e == 10) ? 2'd2 : 2'd0;
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL bounce_w edge %0d got %0d want %0d", e, w, exp_w);
            end
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL bounce_idle got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_repeat();
        logic [1:0] exp_w;
        int pulses;
        pulses = 0;
        for (int e = 1; e <= 50; e++) begin
            key = (e <= 40) ? 3'b011 : 3'b111;
            step();
            exp_w = (e == 7 || e == 16 || e == 25 || e == 34) ? 2'd3 : 2'd0;
            if (w != 2'd0) pulses++;
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL repeat_w edge %0d got %0d want %0d", e, w, exp_w);
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL repeat_count got %0d want 4", pulses);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL repeat_idle got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_priority();
        logic [1:0] exp_w;
        // add1 and sub1 pressed together
        for (int e = 1; e <= 22; e++) begin
            key = (e <= 12) ? 3'b010 : 3'b111;
            step();
            exp_w = (e == 7) ? 2'd3 : 2'd0;
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL prio_both edge %0d got %0d want %0d", e, w, exp_w);
            end
        end
        // sub1 added while add1 is still debouncing
        for (int e = 1; e <= 22; e++) begin
            if (e > 12)     key = 3'b111;
            else if (e < 3) key = 3'b110;
            else            key = 3'b010;
            step();
            exp_w = (e == 10) ? 2'd3 : 2'd0;
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL prio_added edge %0d got %0d want %0d", e, w, exp_w);
            end
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL prio_idle got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_reset_in_fire();
        logic [1:0] exp_w;
        for (int e = 1; e <= 25; e++) begin
            key   = (e <= 16) ? 3'b110 : 3'b111;
            reset = (e == 8) ? 1'b0 : 1'b1;
            step();
            exp_w = (e == 7 || e == 15) ? 2'd1 : 2'd0;
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL rst_fire_w edge %0d got %0d want %0d", e, w, exp_w);
            end
            if (e == 7) begin
                checks++;
                if (state_dbg !== 3'd2) begin
                    errors++;
                    $display("FAIL rst_fire_pre got %0d want 2", state_dbg);
                end
            end
            if (e == 8) begin
                checks++;
                if (state_dbg !== 3'd0) begin
                    errors++;
                    $display("FAIL rst_fire_state got %0d want 0", state_dbg);
                end
            end
        end
        reset = 1'b1;
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL rst_fire_idle got %0d want 0", state_dbg);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        key    = 3'b111;
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_priority();
        test_reset_in_fire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
